// File: rtl/square_linear_unmap.sv
// Recovers an 8-bit pixel from a mapped value: q = floor(din*k_x/k_y), saturated at 255.
// A sequential multiply stage feeds a 16-step restoring divider, with valid/ready on both sides.
module square_linear_unmap #(
  localparam int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] k_x,
  input  logic [DATA_WIDTH-1:0] k_y,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] q
);

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    SAT,
    DONE
  } state_t;

  state_t                  state_q;
  logic                    en_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [DATA_WIDTH-1:0]   kx_q;
  logic [DATA_WIDTH-1:0]   ky_q;
  logic [2*DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0]   divisor_q;
  logic [DATA_WIDTH:0]     rem_q;
  logic [2*DATA_WIDTH-1:0] quo_q;
  logic [3:0]              cnt_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   q_q;

  logic [DATA_WIDTH:0]     rem_shift;
  logic                    take;
  logic [DATA_WIDTH:0]     rem_d;

  // rem_q[8] set means the shifted remainder exceeds any 8-bit divisor; the
  // 9-bit subtraction wraps to the correct value in that case.
  always_comb begin
    rem_shift = {rem_q[DATA_WIDTH-1:0], dividend_q[2*DATA_WIDTH-1]};
    take      = rem_q[DATA_WIDTH] || (rem_shift >= {1'b0, divisor_q});
    rem_d     = rem_shift;
    if (take) begin
      rem_d = rem_shift - {1'b0, divisor_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      din_q       <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            en_q       <= en;
            din_q      <= din;
            kx_q       <= k_x;
            ky_q       <= k_y;
            in_ready_q <= 1'b0;
            state_q    <= MUL;
          end
        end
        MUL: begin
          if (en_q) begin
            dividend_q <= {8'b0, din_q} * {8'b0, kx_q};
          end else begin
            dividend_q <= {8'b0, din_q} * {8'b0, ky_q};
          end
          divisor_q <= ky_q;
          rem_q     <= '0;
          quo_q     <= '0;
          cnt_q     <= '0;
          state_q   <= DIV;
        end
        DIV: begin
          rem_q      <= rem_d;
          quo_q      <= {quo_q[2*DATA_WIDTH-2:0], take};
          dividend_q <= {dividend_q[2*DATA_WIDTH-2:0], 1'b0};
          cnt_q      <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= SAT;
          end
        end
        SAT: begin
          if ((divisor_q == '0) || (quo_q[2*DATA_WIDTH-1:DATA_WIDTH] != '0)) begin
            q_q <= '1;
          end else begin
            q_q <= quo_q[DATA_WIDTH-1:0];
          end
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;

endmodule

// File: tb/tb_square_linear_unmap.sv
// Bench for square_linear_unmap: directed plan cases plus random transactions
// checked against an arithmetic reference of the unmap rule.
module tb_square_linear_unmap;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [7:0] k_x;
  logic [7:0] k_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  square_linear_unmap dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .k_x       (k_x),
    .k_y       (k_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_unmap(input bit m, input int unsigned d,
                                            input int unsigned kx, input int unsigned ky);
    int unsigned num;
    num = m ? d * kx : d * ky;
    if (ky == 0) return 255;
    if (num / ky > 255) return 255;
    return num / ky;
  endfunction

  // Waits for in_ready, accepts one transaction and returns the number of
  // edges from the accept edge until out_valid is first seen (0 on timeout).
  task automatic issue(input bit m, input logic [7:0] d, input logic [7:0] kx,
                       input logic [7:0] ky, input bit scramble, output int unsigned lat);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    en = m; din = d; k_x = kx; k_y = ky; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int unsigned e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        en = 1'($urandom); din = 8'($urandom); k_x = 8'($urandom); k_y = 8'($urandom);
        in_valid = 1'($urandom);
      end
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic full_txn(input string tag, input bit m, input logic [7:0] d,
                          input logic [7:0] kx, input logic [7:0] ky, input bit scramble);
    int unsigned lat;
    out_ready = 1'b1;
    issue(m, d, kx, ky, scramble, lat);
    check({tag, "_latency"}, lat, 18);
    check({tag, "_q"}, q, ref_unmap(m, d, kx, ky));
    @(posedge clk);
    #1;
    check({tag, "_consumed"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int unsigned lat;
    logic [7:0] held_q;
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; din = '0; k_x = '0; k_y = '0; out_ready = 1'b0;
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_q", q, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;

    full_txn("basic", 1'b1, 8'd100, 8'd128, 8'd200, 1'b0);
    check("basic_const", ref_unmap(1'b1, 100, 128, 200), 64);
    full_txn("floor", 1'b1, 8'd10, 8'd3, 8'd7, 1'b0);
    full_txn("sat", 1'b1, 8'd200, 8'd255, 8'd100, 1'b0);
    full_txn("div0", 1'b1, 8'd50, 8'd9, 8'd0, 1'b0);
    full_txn("ident", 1'b0, 8'd77, 8'd5, 8'd33, 1'b0);
    full_txn("ident_div0", 1'b0, 8'd77, 8'd5, 8'd0, 1'b0);
    full_txn("hold", 1'b1, 8'd201, 8'd99, 8'd150, 1'b1);

    // Backpressure with in_valid asserted and din changing
    out_ready = 1'b0;
    issue(1'b1, 8'd90, 8'd40, 8'd30, 1'b0, lat);
    check("bp_latency", lat, 18);
    check("bp_q", q, ref_unmap(1'b1, 90, 40, 30));
    held_q = q;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; din = 8'($urandom);
      @(posedge clk);
      #1;
      check("bp_q_stable", q, held_q);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_no_accept", in_ready, 1);

    // Asynchronous reset in the middle of the divide
    @(negedge clk);
    en = 1'b1; din = 8'd250; k_x = 8'd250; k_y = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_q", q, 0);
    check("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int unsigned i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_output", out_valid, 0);
    end
    full_txn("post_rst", 1'b1, 8'd128, 8'd2, 8'd4, 1'b0);

    // Random traffic with random backpressure
    for (int unsigned t = 0; t < 40; t++) begin
      logic       rm;
      logic [7:0] rd, rkx, rky;
      int unsigned stall;
      rm = 1'($urandom); rd = 8'($urandom); rkx = 8'($urandom);
      rky = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      issue(rm, rd, rkx, rky, 1'($urandom), lat);
      check("rnd_latency", lat, 18);
      check("rnd_q", q, ref_unmap(rm, rd, rkx, rky));
      repeat (stall) begin
        @(posedge clk);
        #1;
        check("rnd_stall_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rnd_consumed", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/square_linear_unmap.md
# square_linear_unmap

Inverse companion to the square linear mapping stage in the ISP scaling path. It recovers a pixel value from a mapped value by computing q = din·k_x / k_y (floor), with saturation at 255. It uses a sequential multiply stage and a 16-iteration restoring divider, and talks valid/ready on both sides. It sits between the mapped-value producer and any consumer that needs original-scale 8-bit data, one transaction in flight at a time.

## Interface
- DATA_WIDTH, 8, operand/result width; fixed, not overridable.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  mode, sampled at accept. 1 = unmap: q = din·k_x/k_y. 0 = identity: q = din·k_y/k_y.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept; high only in IDLE.
- din  in  8  mapped value.
- k_x  in  8  numerator gain.
- k_y  in  8  denominator gain.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- q  out  8  result.

## Operation
- States: IDLE, MUL, DIV, SAT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch en, din, k_x, k_y and go to MUL. Input changes after accept are ignored.
- MUL: register the 16-bit dividend and 8-bit divisor, then go to DIV with iteration counter = 0.
  - en=1: dividend = din·k_x, divisor = k_y.
  - en=0: dividend = din·k_y, divisor = k_y.
- DIV: one restoring-division step per cycle, MSB-first, 16 steps.
  - Each step: shift the partial remainder left by 1 and bring in the next dividend bit. The remainder register is 9 bits.
  - Subtract the divisor if remainder ≥ divisor; the quotient bit is 1 if the subtraction happened.
  - Counter is 4 bits. After step 15 completes, go to SAT.
- SAT: load q as follows, then go to DONE with out_valid=1.
  - divisor==0: q = 0xFF.
  - quotient[15:8] != 0: q = 0xFF.
  - otherwise: q = quotient[7:0].
- DONE: out_valid=1 and q held stable. On out_ready, clear out_valid and return to IDLE. in_valid is ignored until IDLE.
- Reset (asynchronous, any state, including mid-DIV): state=IDLE, out_valid=0, q=0, in_ready=1, counter=0, internal registers=0. The in-flight transaction is discarded with no output.

## Timing
- Accept edge = E0. MUL at E1, DIV steps at E2..E17, SAT at E18.
- out_valid rises after E18, i.e. first visible in the cycle following E18 (18 edges after accept).
- If out_ready is high when out_valid rises, the result is consumed at E19. in_ready is high after E19, and the next accept can occur at E20.
- Maximum throughput: one result per 20 cycles.
- Backpressure: out_valid and q stay constant indefinitely while out_ready=0.
- out_ready while out_valid=0 has no effect.
- in_ready is a registered state decode and never depends combinationally on in_valid or out_ready.
- Arithmetic: unsigned, floor division, no rounding.

## Test plan
- Basic unmap: en=1, din=100, k_x=128, k_y=200 (12800/200) -> q=64. out_valid rises exactly 18 edges after accept.
- Floor and saturation, two transactions in sequence:
  - en=1, din=10, k_x=3, k_y=7 -> q=4.
  - then en=1, din=200, k_x=255, k_y=100 (quotient 510) -> q=0xFF.
- Divide-by-zero and identity:
  - en=1, din=50, k_x=9, k_y=0 -> q=0xFF.
  - en=0, din=77, k_y=33 -> q=77.
  - en=0, din=77, k_y=0 -> q=0xFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, with in_valid=1 and changing din. Required: q stable, out_valid=1, in_ready=0, no new accept. Release out_ready: one handshake, in_ready=1 on the next cycle.
- Operand hold: change din/k_x/k_y/en every cycle after accept. The result must match the values latched at accept.
- Mid-operation reset: assert reset asynchronously (between edges) at E9 of a transaction. Required: out_valid=0, q=0, in_ready=1 immediately, with no spurious output. After deassertion, a new transaction (din=128, k_x=2, k_y=4 -> q=64) completes normally in 18 edges.
